// File: rtl/multi_deque.sv
// multi_deque: CHANNELS independent circular deques with one push/pop per cycle and a registered pop result.
// Define MULTI_DEQUE_LEVEL_EN to add the o_level port (fill count of the channel on i_chan_sel).
module multi_deque #(
    parameter  int CHANNELS = 2,
    parameter  int DEPTH    = 16,
    parameter  int WIDTH    = 8,
    localparam int CW       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
    localparam int NW       = $clog2(DEPTH + 1)
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic [CW-1:0]       i_chan_sel,
    input  logic                i_op_valid,
    input  logic                i_op_pop,
    input  logic                i_op_back,
    input  logic [WIDTH-1:0]    i_data_in,
    output logic [WIDTH-1:0]    o_data_out,
    output logic                o_out_valid,
    output logic                o_error,
    output logic [CHANNELS-1:0] o_empty,
    output logic [CHANNELS-1:0] o_full
`ifdef MULTI_DEQUE_LEVEL_EN
    ,
    output logic [NW-1:0]       o_level
`endif
);
    localparam int PW = $clog2(DEPTH);
    // Wide enough to hold head + count (up to 2*DEPTH-1) before the explicit wrap.
    localparam int SW = NW + 1;

    logic [WIDTH-1:0] r_mem   [CHANNELS][DEPTH];
    logic [PW-1:0]    r_head  [CHANNELS];
    logic [NW-1:0]    r_count [CHANNELS];
    logic [WIDTH-1:0] r_data_out;
    logic             r_out_valid;
    logic             r_error;

    logic          w_sel_ok;
    logic [CW-1:0] w_idx;
    logic [PW-1:0] w_head;
    logic [PW-1:0] w_head_inc;
    logic [PW-1:0] w_head_dec;
    logic [PW-1:0] w_tail_wr;
    logic [PW-1:0] w_tail_rd;
    logic [PW-1:0] w_rd_addr;
    logic [PW-1:0] w_wr_addr;
    logic [NW-1:0] w_cnt;
    logic [SW-1:0] w_sum;
    logic [SW-1:0] w_sum_m1;
    logic          w_is_empty;
    logic          w_is_full;
    logic          w_reject;
    logic          w_do;

    always_comb begin
        w_sel_ok   = (int'(i_chan_sel) < CHANNELS);
        w_idx      = w_sel_ok ? i_chan_sel : '0;
        w_head     = r_head[w_idx];
        w_cnt      = r_count[w_idx];
        w_is_empty = (w_cnt == '0);
        w_is_full  = (w_cnt == NW'(DEPTH));

        w_head_inc = (w_head == PW'(DEPTH - 1)) ? '0 : w_head + PW'(1);
        w_head_dec = (w_head == '0) ? PW'(DEPTH - 1) : w_head - PW'(1);

        w_sum      = SW'(w_head) + SW'(w_cnt);
        w_sum_m1   = w_sum - SW'(1);
        w_tail_wr  = (w_sum >= SW'(DEPTH)) ? PW'(w_sum - SW'(DEPTH)) : PW'(w_sum);
        w_tail_rd  = (w_sum_m1 >= SW'(DEPTH)) ? PW'(w_sum_m1 - SW'(DEPTH)) : PW'(w_sum_m1);

        w_rd_addr  = i_op_back ? w_tail_rd : w_head;
        w_wr_addr  = i_op_back ? w_tail_wr : w_head_dec;

        w_reject   = i_op_valid & (~w_sel_ok | (i_op_pop ? w_is_empty : w_is_full));
        w_do       = i_op_valid & ~w_reject;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int c = 0; c < CHANNELS; c++) begin
                r_head[c]  <= '0;
                r_count[c] <= '0;
            end
            r_data_out  <= '0;
            r_out_valid <= 1'b0;
            r_error     <= 1'b0;
        end else begin
            r_out_valid <= w_do & i_op_pop;
            r_error     <= w_reject;
            if (w_do) begin
                if (i_op_pop) begin
                    r_data_out     <= r_mem[w_idx][w_rd_addr];
                    r_count[w_idx] <= w_cnt - NW'(1);
                    if (!i_op_back) begin
                        r_head[w_idx] <= w_head_inc;
                    end
                end else begin
                    r_count[w_idx] <= w_cnt + NW'(1);
                    if (!i_op_back) begin
                        r_head[w_idx] <= w_head_dec;
                    end
                end
            end
        end
    end

    // Storage has no reset; the pointers alone define which entries are live.
    always_ff @(posedge i_clk) begin
        if (w_do && !i_op_pop) begin
            r_mem[w_idx][w_wr_addr] <= i_data_in;
        end
    end

    for (genvar c = 0; c < CHANNELS; c++) begin : g_flags
        assign o_empty[c] = (r_count[c] == '0);
        assign o_full[c]  = (r_count[c] == NW'(DEPTH));
    end

    assign o_data_out  = r_data_out;
    assign o_out_valid = r_out_valid;
    assign o_error     = r_error;

`ifdef MULTI_DEQUE_LEVEL_EN
    assign o_level = w_sel_ok ? w_cnt : '0;
`endif

endmodule

// File: tb/tb_multi_deque.sv
// Bench for multi_deque: queue-based reference deques feed an expected-output scoreboard
// that a monitor pops against the DUT; scenario tasks add inline flag/data checks.
module tb_multi_deque;
    localparam int DEPTH = 4;

    typedef struct packed {
        logic       pop;
        logic       err;
        logic [7:0] data;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       chan_sel;
    logic       op_valid;
    logic       op_pop;
    logic       op_back;
    logic [7:0] data_in;
    logic [7:0] data_out;
    logic       out_valid;
    logic       error;
    logic [1:0] empty;
    logic [1:0] full;

    logic [1:0] c3_sel;
    logic       c3_valid;
    logic       c3_pop;
    logic       c3_back;
    logic [7:0] c3_din;
    logic [7:0] c3_dout;
    logic       c3_ov;
    logic       c3_err;
    logic [2:0] c3_empty;
    logic [2:0] c3_full;
`ifdef MULTI_DEQUE_LEVEL_EN
    logic [2:0] level;
    logic [2:0] c3_level;
`endif

    int n_cmp  = 0;
    int n_fail = 0;

    logic [7:0] mq0 [$];
    logic [7:0] mq1 [$];
    exp_t       exp_q [$];
    logic [7:0] last_data = 8'h00;

    always #5 clk = ~clk;

    multi_deque #(.CHANNELS(2), .DEPTH(DEPTH), .WIDTH(8)) u_dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_chan_sel (chan_sel),
        .i_op_valid (op_valid),
        .i_op_pop   (op_pop),
        .i_op_back  (op_back),
        .i_data_in  (data_in),
        .o_data_out (data_out),
        .o_out_valid(out_valid),
        .o_error    (error),
        .o_empty    (empty),
        .o_full     (full)
`ifdef MULTI_DEQUE_LEVEL_EN
        ,
        .o_level    (level)
`endif
    );

    multi_deque #(.CHANNELS(3), .DEPTH(DEPTH), .WIDTH(8)) u_dut3 (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_chan_sel (c3_sel),
        .i_op_valid (c3_valid),
        .i_op_pop   (c3_pop),
        .i_op_back  (c3_back),
        .i_data_in  (c3_din),
        .o_data_out (c3_dout),
        .o_out_valid(c3_ov),
        .o_error    (c3_err),
        .o_empty    (c3_empty),
        .o_full     (c3_full)
`ifdef MULTI_DEQUE_LEVEL_EN
        ,
        .o_level    (c3_level)
`endif
    );

    function automatic logic [1:0] exp_empty();
        return {mq1.size() == 0, mq0.size() == 0};
    endfunction

    function automatic logic [1:0] exp_full();
        return {mq1.size() == DEPTH, mq0.size() == DEPTH};
    endfunction

    // Scoreboard monitor: every edge that carried an op pops one expectation.
    initial begin
        bit   sampled;
        exp_t e;
        forever begin
            @(posedge clk);
            sampled = op_valid && !rst;
            #1;
            if (!rst) begin
                n_cmp++;
                if (sampled) begin
                    if (exp_q.size() == 0) begin
                        n_fail++;
                        $display("FAIL mon_unexpected_op: op seen with empty scoreboard at %0t", $time);
                    end else begin
                        e = exp_q.pop_front();
                        if ({out_valid, error, data_out} !== {e.pop, e.err, e.data}) begin
                            n_fail++;
                            $display("FAIL mon_op at %0t: out_valid=%b error=%b data_out=%h, required out_valid=%b error=%b data_out=%h",
                                     $time, out_valid, error, data_out, e.pop, e.err, e.data);
                        end
                    end
                end else if ({out_valid, error, data_out} !== {1'b0, 1'b0, last_data}) begin
                    n_fail++;
                    $display("FAIL mon_idle at %0t: out_valid=%b error=%b data_out=%h, required 0 0 %h",
                             $time, out_valid, error, data_out, last_data);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic drive_op(input int ch, input bit pop, input bit back, input logic [7:0] d);
        exp_t e;
        bit   legal;
        int   sz;
        @(negedge clk);
        sz    = (ch == 0) ? mq0.size() : mq1.size();
        legal = pop ? (sz > 0) : (sz < DEPTH);
        if (legal && pop) begin
            if (ch == 0) last_data = back ? mq0.pop_back() : mq0.pop_front();
            else         last_data = back ? mq1.pop_back() : mq1.pop_front();
        end else if (legal) begin
            if (ch == 0) begin
                if (back) mq0.push_back(d); else mq0.push_front(d);
            end else begin
                if (back) mq1.push_back(d); else mq1.push_front(d);
            end
        end
        e.pop  = legal && pop;
        e.err  = !legal;
        e.data = last_data;
        exp_q.push_back(e);
        chan_sel = ch[0];
        op_pop   = pop;
        op_back  = back;
        data_in  = d;
        op_valid = 1'b1;
        @(posedge clk);
        #2;
        op_valid = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        n_cmp++;
        if (empty !== 2'b11) begin n_fail++; $display("FAIL reset_empty: got %b, required 11", empty); end
        n_cmp++;
        if (full !== 2'b00) begin n_fail++; $display("FAIL reset_full: got %b, required 00", full); end
        n_cmp++;
        if (data_out !== 8'h00) begin n_fail++; $display("FAIL reset_data_out: got %h, required 00", data_out); end
        n_cmp++;
        if ({out_valid, error} !== 2'b00) begin n_fail++; $display("FAIL reset_pulses: got out_valid=%b error=%b, required 0 0", out_valid, error); end
        n_cmp++;
        if (c3_empty !== 3'b111) begin n_fail++; $display("FAIL reset_c3_empty: got %b, required 111", c3_empty); end
        mq0.delete();
        mq1.delete();
        exp_q.delete();
        last_data = 8'h00;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_fifo();
        drive_op(0, 0, 1, 8'h11);
        drive_op(0, 0, 1, 8'h22);
        drive_op(0, 0, 1, 8'h33);
        n_cmp++;
        if (empty !== 2'b10) begin n_fail++; $display("FAIL fifo_filled_empty: got %b, required 10", empty); end
        for (int i = 0; i < 3; i++) drive_op(0, 1, 0, 8'h00);
        n_cmp++;
        if (data_out !== 8'h33 || empty !== 2'b11) begin
            n_fail++;
            $display("FAIL fifo_drained: got data_out=%h empty=%b, required 33 11", data_out, empty);
        end
    endtask

    task automatic test_deque();
        logic [10:0] tbl [6] = '{
            {1'b1, 1'b0, 1'b0, 8'hA1}, {1'b1, 1'b0, 1'b0, 8'hA2}, {1'b1, 1'b1, 1'b0, 8'h00},
            {1'b1, 1'b0, 1'b1, 8'hB0}, {1'b1, 1'b1, 1'b1, 8'h00}, {1'b1, 1'b1, 1'b1, 8'h00}};
        drive_op(0, 0, 1, 8'h5C);
        for (int i = 0; i < 6; i++) begin
            drive_op(int'(tbl[i][10]), tbl[i][9], tbl[i][8], tbl[i][7:0]);
            n_cmp++;
            if (empty !== exp_empty() || full !== exp_full()) begin
                n_fail++;
                $display("FAIL deque_flags step %0d: empty=%b full=%b, required empty=%b full=%b",
                         i, empty, full, exp_empty(), exp_full());
            end
        end
        n_cmp++;
        if (data_out !== 8'hA1) begin n_fail++; $display("FAIL deque_last_pop: got %h, required a1", data_out); end
    endtask

    task automatic test_overflow();
        for (int i = 1; i <= 4; i++) drive_op(0, 0, 1, 8'(i));
        n_cmp++;
        if (full !== 2'b01) begin n_fail++; $display("FAIL ovf_full: got %b, required 01", full); end
        drive_op(0, 0, 1, 8'h05);
        n_cmp++;
        if (full !== 2'b01 || empty !== 2'b10) begin
            n_fail++;
            $display("FAIL ovf_reject_state: got full=%b empty=%b, required 01 10", full, empty);
        end
        drive_op(0, 1, 1, 8'h00);
        n_cmp++;
        if (data_out !== 8'h04) begin n_fail++; $display("FAIL ovf_pop_back: got %h, required 04", data_out); end
    endtask

    task automatic test_wrap();
        for (int i = 1; i <= 4; i++) drive_op(0, 0, 1, 8'(i));
        drive_op(0, 1, 0, 8'h00);
        drive_op(0, 1, 0, 8'h00);
        drive_op(0, 0, 1, 8'h05);
        drive_op(0, 0, 1, 8'h06);
        n_cmp++;
        if (full !== 2'b01) begin n_fail++; $display("FAIL wrap_full: got %b, required 01", full); end
        for (int i = 0; i < 4; i++) drive_op(0, 1, 0, 8'h00);
        n_cmp++;
        if (data_out !== 8'h06 || empty !== 2'b11) begin
            n_fail++;
            $display("FAIL wrap_drain: got data_out=%h empty=%b, required 06 11", data_out, empty);
        end
        test_reset();
        drive_op(1, 0, 0, 8'h77);
        drive_op(1, 1, 1, 8'h00);
        n_cmp++;
        if (data_out !== 8'h77) begin n_fail++; $display("FAIL wrap_front_head: got %h, required 77", data_out); end
    endtask

    task automatic test_underflow();
        drive_op(1, 1, 0, 8'h00);
        n_cmp++;
        if (data_out !== last_data || empty !== 2'b11) begin
            n_fail++;
            $display("FAIL underflow_hold: got data_out=%h empty=%b, required %h 11", data_out, empty, last_data);
        end
    endtask

    task automatic test_illegal_sel();
        logic [11:0] tbl [4] = '{
            {2'd0, 1'b0, 1'b1, 8'h5A}, {2'd3, 1'b0, 1'b1, 8'h66},
            {2'd3, 1'b1, 1'b0, 8'h00}, {2'd0, 1'b1, 1'b1, 8'h00}};
        logic [1:0] exp_oe  [4] = '{2'b00, 2'b01, 2'b01, 2'b10};
        logic [7:0] exp_dat [4] = '{8'h00, 8'h00, 8'h00, 8'h5A};
        logic [2:0] exp_emp [4] = '{3'b110, 3'b110, 3'b110, 3'b111};
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            c3_sel   = tbl[i][11:10];
            c3_pop   = tbl[i][9];
            c3_back  = tbl[i][8];
            c3_din   = tbl[i][7:0];
            c3_valid = 1'b1;
            @(posedge clk);
            #1;
            c3_valid = 1'b0;
            n_cmp++;
            if ({c3_ov, c3_err} !== exp_oe[i] || c3_dout !== exp_dat[i] ||
                c3_empty !== exp_emp[i] || c3_full !== 3'b000) begin
                n_fail++;
                $display("FAIL illegal_sel step %0d: ov/err=%b dout=%h empty=%b full=%b, required %b %h %b 000",
                         i, {c3_ov, c3_err}, c3_dout, c3_empty, c3_full, exp_oe[i], exp_dat[i], exp_emp[i]);
            end
        end
    endtask

    task automatic test_reset_mid_op();
        drive_op(0, 0, 1, 8'h99);
        @(negedge clk);
        chan_sel = 1'b1;
        op_pop   = 1'b0;
        op_back  = 1'b1;
        data_in  = 8'hEE;
        op_valid = 1'b1;
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        n_cmp++;
        if (empty !== 2'b11 || full !== 2'b00 || out_valid !== 1'b0 || error !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid_op: empty=%b full=%b ov=%b err=%b, required 11 00 0 0", empty, full, out_valid, error);
        end
        mq0.delete();
        mq1.delete();
        exp_q.delete();
        last_data = 8'h00;
        @(negedge clk);
        op_valid = 1'b0;
        rst      = 1'b0;
        @(posedge clk);
        #2;
        n_cmp++;
        if (empty !== 2'b11 || data_out !== 8'h00) begin
            n_fail++;
            $display("FAIL rst_mid_op_discard: empty=%b data_out=%h, required 11 00", empty, data_out);
        end
    endtask

    task automatic test_back_to_back();
        int         ch;
        bit         pop;
        bit         back;
        logic [7:0] d;
        for (int i = 0; i < 48; i++) begin
            ch   = int'($urandom_range(0, 1));
            pop  = 1'($urandom_range(0, 1));
            back = 1'($urandom_range(0, 1));
            d    = 8'($urandom);
            drive_op(ch, pop, back, d);
            n_cmp++;
            if (empty !== exp_empty() || full !== exp_full()) begin
                n_fail++;
                $display("FAIL b2b_flags op %0d: empty=%b full=%b, required empty=%b full=%b",
                         i, empty, full, exp_empty(), exp_full());
            end
        end
    endtask

    initial begin
        rst      = 1'b1;
        chan_sel = 1'b0;
        op_valid = 1'b0;
        op_pop   = 1'b0;
        op_back  = 1'b0;
        data_in  = 8'h00;
        c3_sel   = 2'd0;
        c3_valid = 1'b0;
        c3_pop   = 1'b0;
        c3_back  = 1'b0;
        c3_din   = 8'h00;
        #12;
        rst = 1'b0;

        test_reset();
        test_fifo();
        test_deque();
        test_reset();
        test_overflow();
        test_reset();
        test_wrap();
        test_underflow();
        test_illegal_sel();
        test_reset_mid_op();
        test_back_to_back();

        repeat (2) @(posedge clk);
        #2;
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/multi_deque.md
Name: multi_deque

Overview:
- Parametrised successor to the dual stack block. Provides CHANNELS independent double-ended queues, each DEPTH entries of WIDTH bits.
- Either end of the selected channel can be pushed or popped, so each channel works as a stack, a FIFO, or a full deque.
- Sits behind the same single-operation-per-cycle command interface used by the existing stack front end.
- Adds registered pop data and overflow/underflow signalling.

Parameters:
- CHANNELS, 2, number of independent deques (>=1).
- DEPTH, 16, entries per channel (>=2, need not be a power of two).
- WIDTH, 8, data word width.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- chan_sel  in  CW  target channel; CW = max(1, clog2(CHANNELS)).
- op_valid  in  1  execute one operation this cycle.
- op_pop  in  1  1 = pop, 0 = push.
- op_back  in  1  1 = back end, 0 = front end.
- data_in  in  WIDTH  push data.
- data_out  out  WIDTH  last popped word (registered).
- out_valid  out  1  one-cycle pulse when data_out has just been updated by a pop.
- error  out  1  one-cycle pulse on a rejected operation.
- empty  out  CHANNELS  per-channel empty flag.
- full  out  CHANNELS  per-channel full flag.

Behaviour:
- Per-channel state: circular storage, head pointer (0..DEPTH-1), count (0..DEPTH).
- Wrap is explicit: increment past DEPTH-1 goes to 0; decrement below 0 goes to DEPTH-1.
- Storage is not reset. Pointers, counts and outputs are.
- Reset, asynchronous and checked at any time including mid-operation:
  - all heads and counts = 0; data_out = 0; out_valid = 0; error = 0.
  - empty = all ones; full = all zeros.
- Flags are combinational from count: empty[c] = (count==0), full[c] = (count==DEPTH).
- Operations apply only when op_valid=1 and take effect at the clk edge. Encoding is {op_pop, op_back}:
  - 00 push_front: head <= head-1 (wrap), mem[head-1] <= data_in, count+1.
  - 01 push_back: mem[(head+count) wrap] <= data_in, count+1.
  - 10 pop_front: data_out <= mem[head], head+1 (wrap), count-1.
  - 11 pop_back: data_out <= mem[(head+count-1) wrap], count-1.
- Latency: popped word is on data_out with out_valid=1 in the cycle after the op edge. data_out holds until the next successful pop.
- Rejected operations leave all state unchanged, including data_out, and pulse error=1 for one cycle with out_valid=0:
  - push to a full channel;
  - pop from an empty channel;
  - chan_sel >= CHANNELS.
- out_valid and error are both 0 whenever op_valid=0 or the operation was a successful push.
- At most one channel changes per cycle. Non-selected channels are untouched.
- The data pins have no same-cycle bypass between push and pop; one op per cycle makes it unnecessary.

Optional Feature:
- Macro: MULTI_DEQUE_LEVEL_EN.
- When defined: adds output port level, clog2(DEPTH+1) bits. It is the combinational count of the channel on chan_sel, and 0 if chan_sel is out of range. It reads 0 after reset.
- When undefined: the port and its logic are absent. All other behaviour is identical.

Test Plan (CHANNELS=2, DEPTH=4, WIDTH=8):
- Reset: assert rst asynchronously mid-cycle -> empty=2'b11, full=2'b00, data_out=0x00, out_valid=0, error=0 with no clock edge.
- FIFO mode: ch0 push_back 0x11, 0x22, 0x33, then pop_front x3 -> data_out 0x11, 0x22, 0x33 on successive cycles, each with out_valid=1; empty[0]=1 afterwards.
- Stack/deque mode: ch1 push_front 0xA1, 0xA2, then pop_front -> 0xA2. Then push_back 0xB0, pop_back -> 0xB0, pop_back -> 0xA1. Throughout, ch0 flags are unchanged.
- Overflow: ch0 push_back 0x01..0x04 -> full[0]=1. Push_back 0x05 -> error pulse, out_valid=0, no state change. pop_back -> 0x04.
- Wrap-around: ch0 push_back 0x01..0x04, pop_front x2 (0x01, 0x02), push_back 0x05, 0x06 -> full[0]=1; pop_front x4 -> 0x03, 0x04, 0x05, 0x06. Separately, push_front into an empty channel wraps head to 3, then pop_back returns that word.
- Underflow / illegal select: pop_front on empty ch1 -> error=1, data_out holds its previous value. With CHANNELS=3, chan_sel=3 push -> error=1, all counts unchanged. Reset asserted while op_valid=1 -> operation discarded, flags return to reset values.
